// File: rtl/common_pkg.sv
// ============================================================================
// Module      : common (package)
// Description : Project-wide base types shared by every block.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package common;

    typedef logic [31:0] word_t;

endpackage

`default_nettype wire

// File: rtl/cpu_common_pkg.sv
// ============================================================================
// Module      : cpu_common (package)
// Description : CPU-level types: ALU modes, requester ids and ALU request struct.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_common;

    import common::*;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_mode_t;

    typedef logic alu_port_t;

    typedef struct packed {
        alu_mode_t mode;
        word_t     op1;
        word_t     op2;
    } alu_req_t;

endpackage

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module      : alu
// Description : Purely combinational 32-bit integer ALU.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu
    import common::*;
    import cpu_common::*;
(
    input  alu_mode_t mode_i,
    input  word_t     op1_i,
    input  word_t     op2_i,
    output word_t     result_o
);

    logic [4:0] shamt;

    always_comb begin
        shamt    = op2_i[4:0];
        result_o = '0;
        case (mode_i)
            ALU_ADD:  result_o = op1_i + op2_i;
            ALU_SUB:  result_o = op1_i - op2_i;
            ALU_AND:  result_o = op1_i & op2_i;
            ALU_OR:   result_o = op1_i | op2_i;
            ALU_XOR:  result_o = op1_i ^ op2_i;
            ALU_SLL:  result_o = op1_i << shamt;
            ALU_SRL:  result_o = op1_i >> shamt;
            ALU_SRA:  result_o = word_t'($signed(op1_i) >>> shamt);
            ALU_SLT:  result_o = {31'b0, ($signed(op1_i) < $signed(op2_i))};
            ALU_SLTU: result_o = {31'b0, (op1_i < op2_i)};
            default:  result_o = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one ALU between two requesters through a single tagged
//               result slot. ALU_ARBITER_ROUND_ROBIN_EN selects round-robin
//               (defined) or fixed port-0 priority (undefined).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_arbiter
    import common::*;
    import cpu_common::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  alu_mode_t [1:0]       req_mode_i,
    input  logic [1:0][31:0]      req_op1_i,
    input  logic [1:0][31:0]      req_op2_i,
    input  logic [1:0]            req_valid_i,
    output logic [1:0]            req_ready_o,
    output logic [31:0]           resp_result_o,
    output logic [1:0]            resp_valid_o,
    input  logic [1:0]            resp_ready_i,
    output logic                  busy_o
);

    if (NUM_PORTS != 2) begin : g_num_ports_check
        $error("alu_arbiter: NUM_PORTS must be 2");
    end

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    slot_state_t state_q, state_d;
    alu_port_t   owner_q, owner_d;
    word_t       result_q, result_d;
    word_t       alu_result;
    alu_req_t    req_sel;
    alu_port_t   sel;
    alu_port_t   prio;
    logic [1:0]  grant;
    logic        drain;
    logic        slot_free;
    logic        accept;

`ifdef ALU_ARBITER_ROUND_ROBIN_EN
    alu_port_t prio_q, prio_d;
    assign prio = prio_q;
`else
    assign prio = 1'b0;
`endif

    always_comb begin : arbitrate
        drain     = (state_q == SLOT_FULL) && resp_ready_i[owner_q];
        slot_free = (state_q == SLOT_EMPTY) || drain;
        grant     = 2'b00;
        sel       = prio;
        if (req_valid_i[prio]) begin
            grant[prio] = 1'b1;
            sel         = prio;
        end else if (req_valid_i[~prio]) begin
            grant[~prio] = 1'b1;
            sel          = ~prio;
        end
        // Ready is masked during reset so no request can look accepted.
        req_ready_o = (slot_free && rst_ni) ? grant : 2'b00;
        accept      = |(req_valid_i & req_ready_o);
        req_sel     = '{mode: req_mode_i[sel], op1: req_op1_i[sel], op2: req_op2_i[sel]};
    end

    alu u_alu (
        .mode_i   (req_sel.mode),
        .op1_i    (req_sel.op1),
        .op2_i    (req_sel.op2),
        .result_o (alu_result)
    );

    always_comb begin : slot_next
        state_d  = state_q;
        owner_d  = owner_q;
        result_d = result_q;
        if (accept) begin
            state_d  = SLOT_FULL;
            owner_d  = sel;
            result_d = alu_result;
        end else if (drain) begin
            state_d  = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= SLOT_EMPTY;
            owner_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            result_q <= result_d;
        end
    end

`ifdef ALU_ARBITER_ROUND_ROBIN_EN
    always_comb begin : prio_next
        prio_d = prio_q;
        if (accept) begin
            prio_d = ~sel;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    always_comb begin : outputs
        resp_valid_o  = 2'b00;
        if (state_q == SLOT_FULL) begin
            resp_valid_o[owner_q] = 1'b1;
        end
        resp_result_o = result_q;
        busy_o        = (state_q == SLOT_FULL);
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed self-checking bench for alu_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

    import cpu_common::*;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    alu_mode_t [1:0]  req_mode;
    logic [1:0][31:0] req_op1;
    logic [1:0][31:0] req_op2;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [31:0]      resp_result;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic rr_next = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_PORTS(2)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .req_mode_i    (req_mode),
        .req_op1_i     (req_op1),
        .req_op2_i     (req_op2),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .resp_result_o (resp_result),
        .resp_valid_o  (resp_valid),
        .resp_ready_i  (resp_ready),
        .busy_o        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input alu_mode_t m, input logic [31:0] a, input logic [31:0] b);
        req_mode[p] = m;
        req_op1[p]  = a;
        req_op2[p]  = b;
    endtask

    function automatic logic exp_grant_both();
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
        return rr_next;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [1:0] onehot(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

    task automatic note_accept(input logic p);
        rr_next = ~p;
    endtask

    initial begin
        logic g;
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        set_req(0, ALU_ADD, 32'd1, 32'd2);
        set_req(1, ALU_ADD, 32'd3, 32'd4);

        // Reset held with both requesters valid
        tick();
        chk("rst_resp_valid", {30'b0, resp_valid}, 32'd0);
        chk("rst_result", resp_result, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ready", {30'b0, req_ready}, 32'd0);
        tick();
        chk("rst_ready_2", {30'b0, req_ready}, 32'd0);
        req_valid = 2'b00;
        rst_ni    = 1'b1;
        #1;
        chk("post_rst_busy", {31'b0, busy}, 32'd0);
        chk("post_rst_ready_idle", {30'b0, req_ready}, 32'd0);

        // Single op on port 0: ADD 5+7
        set_req(0, ALU_ADD, 32'd5, 32'd7);
        req_valid = 2'b01;
        #1;
        chk("single_ready", {30'b0, req_ready}, 32'h1);
        tick();
        note_accept(1'b0);
        chk("single_valid", {30'b0, resp_valid}, 32'h1);
        chk("single_result", resp_result, 32'd12);
        chk("single_busy", {31'b0, busy}, 32'd1);
        req_valid = 2'b00;
        tick();
        chk("drain_empty_valid", {30'b0, resp_valid}, 32'd0);
        chk("drain_empty_busy", {31'b0, busy}, 32'd0);

        // Port 1 SUB, then back-to-back port-0 ops of various modes
        set_req(1, ALU_SUB, 32'd10, 32'd3);
        req_valid = 2'b10;
        #1;
        chk("p1_ready", {30'b0, req_ready}, 32'h2);
        tick();
        note_accept(1'b1);
        chk("p1_valid", {30'b0, resp_valid}, 32'h2);
        chk("p1_result", resp_result, 32'd7);

        set_req(0, ALU_AND, 32'hffff_0000, 32'h1234_5678);
        req_valid = 2'b01;
        #1;
        chk("and_ready", {30'b0, req_ready}, 32'h1);
        tick();
        note_accept(1'b0);
        chk("and_valid", {30'b0, resp_valid}, 32'h1);
        chk("and_result", resp_result, 32'h1234_0000);

        set_req(0, ALU_SLT, 32'hffff_ffff, 32'd1);
        tick();
        note_accept(1'b0);
        chk("slt_result", resp_result, 32'd1);

        set_req(0, ALU_SLTU, 32'hffff_ffff, 32'd1);
        tick();
        note_accept(1'b0);
        chk("sltu_result", resp_result, 32'd0);

        set_req(0, ALU_SRA, 32'h8000_0000, 32'd4);
        tick();
        note_accept(1'b0);
        chk("sra_result", resp_result, 32'hf800_0000);
        chk("sra_valid", {30'b0, resp_valid}, 32'h1);

        // Contention: both valid for 4 cycles, responses always ready
        set_req(0, ALU_ADD, 32'd1, 32'd1);
        set_req(1, ALU_OR, 32'h0000_00f0, 32'h0000_000f);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            g = exp_grant_both();
            #1;
            chk($sformatf("cont_ready_%0d", i), {30'b0, req_ready}, {30'b0, onehot(g)});
            tick();
            note_accept(g);
            chk($sformatf("cont_valid_%0d", i), {30'b0, resp_valid}, {30'b0, onehot(g)});
            chk($sformatf("cont_result_%0d", i), resp_result, g ? 32'h0000_00ff : 32'd2);
        end
        req_valid = 2'b00;
        tick();
        chk("cont_drained", {31'b0, busy}, 32'd0);

        // Back-pressure: port 1 owns the slot and stalls
        set_req(1, ALU_SUB, 32'd50, 32'd8);
        req_valid  = 2'b10;
        resp_ready = 2'b01;
        #1;
        chk("bp_p1_ready", {30'b0, req_ready}, 32'h2);
        tick();
        note_accept(1'b1);
        chk("bp_p1_valid", {30'b0, resp_valid}, 32'h2);
        chk("bp_p1_result", resp_result, 32'd42);
        set_req(0, ALU_ADD, 32'd3, 32'd4);
        req_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_stall_ready_%0d", i), {30'b0, req_ready}, 32'd0);
            tick();
            chk($sformatf("bp_stall_valid_%0d", i), {30'b0, resp_valid}, 32'h2);
            chk($sformatf("bp_stall_result_%0d", i), resp_result, 32'd42);
        end
        resp_ready = 2'b11;
        #1;
        chk("bp_release_ready", {30'b0, req_ready}, 32'h1);
        tick();
        note_accept(1'b0);
        chk("bp_release_valid", {30'b0, resp_valid}, 32'h1);
        chk("bp_release_result", resp_result, 32'd7);

        // Stall with no requester, then async reset while the slot is full
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        tick();
        chk("hold_valid", {30'b0, resp_valid}, 32'h1);
        chk("hold_busy", {31'b0, busy}, 32'd1);
        #2;
        rst_ni    = 1'b0;
        req_valid = 2'b01;
        #1;
        chk("arst_valid", {30'b0, resp_valid}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_result", resp_result, 32'd0);
        chk("arst_ready", {30'b0, req_ready}, 32'd0);
        tick();
        rst_ni     = 1'b1;
        resp_ready = 2'b11;
        rr_next    = 1'b0;
        #1;
        chk("arst_after_busy", {31'b0, busy}, 32'd0);
        chk("arst_after_ready", {30'b0, req_ready}, 32'h1);
        tick();
        chk("arst_reissue_valid", {30'b0, resp_valid}, 32'h1);
        chk("arst_reissue_result", resp_result, 32'd7);
        req_valid = 2'b00;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
